// File: rtl/kbd_ascii_ctrl.sv
// kbd_ascii_ctrl: PS/2 keyboard sequencer between the byte receiver and the
// scancode-to-ASCII ROM. It parses make/break/extended prefixes, tracks the
// Shift/Ctrl/CapsLock modifiers, applies case and control folding to the ROM
// output, and queues the resulting characters in a show-ahead FIFO.
module kbd_ascii_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_rd,
    output logic       shift_on,
    output logic       ctrl_on,
    output logic       caps_on,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]         CODE_EXT_C    = 8'hE0;
    localparam logic [7:0]         CODE_BRK_C    = 8'hF0;
    localparam logic [7:0]         CODE_LSHIFT_C = 8'h12;
    localparam logic [7:0]         CODE_RSHIFT_C = 8'h59;
    localparam logic [7:0]         CODE_CTRL_C   = 8'h14;
    localparam logic [7:0]         CODE_CAPS_C   = 8'h58;
    localparam logic [FIFO_AW:0]   DEPTH_C       = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ZERO_C    = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]   CNT_ONE_C     = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ZERO_C    = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE_C     = {{(FIFO_AW - 1){1'b0}}, 1'b1};

    state_t             state_r;
    logic               lookup_valid_r;
    logic               lshift_r;
    logic               rshift_r;
    logic               ctrl_r;
    logic               caps_r;
    logic               overflow_r;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_r;
    logic [FIFO_AW-1:0] rptr_r;
    logic [FIFO_AW:0]   count_r;

    logic [7:0]         char_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_en_s;
    logic               drop_s;

    // True for the lowercase ASCII letters 'a'..'z'.
    function automatic logic is_lower(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

    // Prefix FSM, modifier tracking and ROM address/lookup strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            rom_addr       <= 8'h00;
            lookup_valid_r <= 1'b0;
            lshift_r       <= 1'b0;
            rshift_r       <= 1'b0;
            ctrl_r         <= 1'b0;
            caps_r         <= 1'b0;
        end else begin
            lookup_valid_r <= 1'b0;
            if (scan_ready) begin
                case (state_r)
                    ST_IDLE: begin
                        if (scan_code == CODE_EXT_C) begin
                            state_r <= ST_EXT;
                        end else if (scan_code == CODE_BRK_C) begin
                            state_r <= ST_BRK;
                        end else begin
                            state_r <= ST_IDLE;
                            case (scan_code)
                                CODE_LSHIFT_C: lshift_r <= 1'b1;
                                CODE_RSHIFT_C: rshift_r <= 1'b1;
                                CODE_CTRL_C:   ctrl_r   <= 1'b1;
                                CODE_CAPS_C:   caps_r   <= ~caps_r;
                                default: begin
                                    rom_addr       <= scan_code;
                                    lookup_valid_r <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_BRK: begin
                        case (scan_code)
                            CODE_LSHIFT_C: lshift_r <= 1'b0;
                            CODE_RSHIFT_C: rshift_r <= 1'b0;
                            CODE_CTRL_C:   ctrl_r   <= 1'b0;
                            default: begin
                            end
                        endcase
                        state_r <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (scan_code == CODE_BRK_C) begin
                            state_r <= ST_EXT_BRK;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: state_r <= ST_IDLE;
                    default:    state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Lookup stage: fold the ROM character with the modifiers held this cycle.
    always_comb begin
        char_s = 8'h00;
        push_s = 1'b0;
        if (lookup_valid_r && (rom_data != 8'h00)) begin
            push_s = 1'b1;
            if (ctrl_r && is_lower(rom_data)) begin
                char_s = rom_data & 8'h1F;
            end else if (is_lower(rom_data) && ((lshift_r | rshift_r) ^ caps_r)) begin
                char_s = rom_data - 8'h20;
            end else begin
                char_s = rom_data;
            end
        end else begin
            char_s = 8'h00;
            push_s = 1'b0;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so a full FIFO can
    // accept a push only when it is popped simultaneously.
    always_comb begin
        pop_s   = ascii_rd && (count_r != CNT_ZERO_C);
        full_s  = (count_r == DEPTH_C);
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;
    end

    // FIFO storage, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r     <= PTR_ZERO_C;
            rptr_r     <= PTR_ZERO_C;
            count_r    <= CNT_ZERO_C;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wptr_r] <= char_s;
                wptr_r        <= wptr_r + PTR_ONE_C;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE_C;
            end else begin
                rptr_r <= rptr_r;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign ascii_valid = (count_r != CNT_ZERO_C);
    assign ascii_data  = (count_r != CNT_ZERO_C) ? mem_r[rptr_r] : 8'h00;
    assign shift_on    = lshift_r | rshift_r;
    assign ctrl_on     = ctrl_r;
    assign caps_on     = caps_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_kbd_ascii_ctrl.sv
// Bench for kbd_ascii_ctrl: directed scenarios plus random byte streams,
// compared every cycle against a keystroke-level reference model.
module tb_kbd_ascii_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_rd;
    logic       shift_on;
    logic       ctrl_on;
    logic       caps_on;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    kbd_ascii_ctrl #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_ready(scan_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .ascii_data(ascii_data),
        .ascii_valid(ascii_valid), .ascii_rd(ascii_rd), .shift_on(shift_on),
        .ctrl_on(ctrl_on), .caps_on(caps_on), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Scancode-to-ASCII ROM (part of the environment).
    function automatic logic [7:0] rom_lookup(input logic [7:0] a);
        case (a)
            8'h1C:   return 8'h61;
            8'h16:   return 8'h31;
            8'h29:   return 8'h20;
            8'h1A:   return 8'h7A;
            8'h0E:   return 8'h60;
            8'h54:   return 8'h7B;
            8'h15:   return 8'h71;
            8'h4E:   return 8'h2D;
            default: return 8'h00;
        endcase
    endfunction

    always_comb rom_data = rom_lookup(rom_addr);

    // ---------------- reference model ----------------
    byte unsigned q[$];
    bit   m_lshift, m_rshift, m_ctrl, m_caps, m_ovf;
    bit   m_ext_seen, m_brk_seen, m_pending;
    logic [7:0] m_pcode, m_addr;

    function automatic logic [7:0] fold(input logic [7:0] c, input bit sh,
                                        input bit ct, input bit cp);
        if (c >= 8'h61 && c <= 8'h7A) begin
            if (ct) return c % 32;
            if (sh != cp) return c - 8'd32;
        end
        return c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_caps = 0; m_ovf = 0;
        m_ext_seen = 0; m_brk_seen = 0; m_pending = 0;
        m_pcode = 8'h00; m_addr = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_ext_seen && !m_brk_seen) begin
            if (b == 8'hE0) m_ext_seen = 1;
            else if (b == 8'hF0) m_brk_seen = 1;
            else if (b == 8'h12) m_lshift = 1;
            else if (b == 8'h59) m_rshift = 1;
            else if (b == 8'h14) m_ctrl = 1;
            else if (b == 8'h58) m_caps = !m_caps;
            else begin m_pending = 1; m_pcode = b; m_addr = b; end
        end else if (m_brk_seen && !m_ext_seen) begin
            if (b == 8'h12) m_lshift = 0;
            else if (b == 8'h59) m_rshift = 0;
            else if (b == 8'h14) m_ctrl = 0;
            m_brk_seen = 0;
        end else if (m_ext_seen && !m_brk_seen) begin
            if (b == 8'hF0) m_brk_seen = 1;
            else m_ext_seen = 0;
        end else begin
            m_ext_seen = 0; m_brk_seen = 0;
        end
    endtask

    task automatic model_cycle(input logic [7:0] b, input bit rdy, input bit rd);
        logic [7:0] c;
        bit was_full, do_pop;
        was_full = (q.size() == 8);
        do_pop   = rd && (q.size() > 0);
        c = m_pending ? fold(rom_lookup(m_pcode), m_lshift | m_rshift, m_ctrl, m_caps) : 8'h00;
        m_pending = 0;
        if (do_pop) void'(q.pop_front());
        if (c != 8'h00) begin
            if (was_full && !do_pop) m_ovf = 1;
            else q.push_back(c);
        end
        if (rdy) model_byte(b);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("valid", ascii_valid, (q.size() > 0));
        check("data", ascii_data, (q.size() > 0) ? q[0] : 8'h00);
        check("shift", shift_on, m_lshift | m_rshift);
        check("ctrl", ctrl_on, m_ctrl);
        check("caps", caps_on, m_caps);
        check("ovf", overflow, m_ovf);
        check("addr", rom_addr, m_addr);
    endtask

    task automatic step(input logic [7:0] b, input bit rdy, input bit rd);
        scan_code  = b;
        scan_ready = rdy;
        ascii_rd   = rd;
        @(posedge clk);
        model_cycle(b, rdy, rd);
        #1;
        scan_ready = 1'b0;
        ascii_rd   = 1'b0;
        compare_all();
    endtask

    task automatic sendb(input logic [7:0] b);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, ascii_valid, 1'b0);
        check({tag, "_data"}, ascii_data, 8'h00);
        check({tag, "_shift"}, shift_on, 1'b0);
        check({tag, "_ctrl"}, ctrl_on, 1'b0);
        check({tag, "_caps"}, caps_on, 1'b0);
        check({tag, "_ovf"}, overflow, 1'b0);
        check({tag, "_addr"}, rom_addr, 8'h00);
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h58, 8'h1C,
                              8'h16, 8'h29, 8'h1A, 8'h0E, 8'h54, 8'h21, 8'h15};

    initial begin
        rst = 1'b1; scan_code = 8'h00; scan_ready = 1'b0; ascii_rd = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Plain make, then break adds nothing, then pop.
        sendb(8'h1C);
        idle(1);
        check("t1_valid", ascii_valid, 1'b1);
        check("t1_data", ascii_data, 8'h61);
        sendb(8'hF0); sendb(8'h1C); idle(2);
        pop();
        check("t1_empty", ascii_valid, 1'b0);

        // Shift held across two lookups, released by break.
        sendb(8'h12); sendb(8'h1C); sendb(8'h16); sendb(8'hF0); sendb(8'h12); sendb(8'h1C);
        idle(2);
        check("t2_shift", shift_on, 1'b0);
        check("t2_h0", ascii_data, 8'h41); pop();
        check("t2_h1", ascii_data, 8'h31); pop();
        check("t2_h2", ascii_data, 8'h61); pop();

        // CapsLock toggling, shift cancelling caps, ctrl folding.
        sendb(8'h58);
        check("t3_caps1", caps_on, 1'b1);
        sendb(8'h1C); sendb(8'h12); sendb(8'h1C); sendb(8'h58);
        check("t3_caps0", caps_on, 1'b0);
        sendb(8'hF0); sendb(8'h12);
        sendb(8'h14); sendb(8'h1C); idle(2);
        check("t3_h0", ascii_data, 8'h41); pop();
        check("t3_h1", ascii_data, 8'h61); pop();
        check("t3_h2", ascii_data, 8'h01); pop();
        sendb(8'hF0); sendb(8'h14);

        // Extended keys and an unmapped code produce nothing.
        sendb(8'hE0); sendb(8'h1C); sendb(8'hE0); sendb(8'hF0); sendb(8'h1C); sendb(8'h21);
        idle(2);
        check("t4_none", ascii_valid, 1'b0);
        sendb(8'h1C); idle(1);
        check("t4_a", ascii_data, 8'h61); pop();

        // Fill past depth, then push and pop together while full.
        for (int i = 0; i < 9; i++) sendb(8'h1C);
        idle(2);
        check("t5_ovf", overflow, 1'b1);
        sendb(8'h16);
        pop();
        for (int i = 0; i < 7; i++) pop();
        check("t5_last", ascii_data, 8'h31);
        check("t5_left", ascii_valid, 1'b1);
        pop();
        check("t5_empty", ascii_valid, 1'b0);

        // Reset in the middle of a break sequence.
        sendb(8'h12); sendb(8'h1C); sendb(8'hF0);
        rst = 1'b1;
        #2;
        model_reset();
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendb(8'h1C); idle(1);
        check("t6_a", ascii_data, 8'h61);
        check("t6_shift", shift_on, 1'b0);
        pop();

        // Random byte streams with random pops.
        for (int i = 0; i < 3000; i++) begin
            step(pool[$urandom_range(0, 13)], ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 35));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
